// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the JK modulo counter: default geometry and the J/K
// operation encoding used by the flip-flop and the next-state decode.
package jk_mod_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_e;

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/data bundle of the JK modulo counter; the optional Gray output G
// exists only when JK_CNT_GRAY_OUT_EN is defined.
interface jk_mod_counter_if
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_n;
    logic             TC;
`ifdef JK_CNT_GRAY_OUT_EN
    logic [WIDTH-1:0] G;
`endif

`ifdef JK_CNT_GRAY_OUT_EN
    modport master (output EN, UP, LOAD, D, input Q, Q_n, TC, G);
    modport slave  (input EN, UP, LOAD, D, output Q, Q_n, TC, G);
`else
    modport master (output EN, UP, LOAD, D, input Q, Q_n, TC);
    modport slave  (input EN, UP, LOAD, D, output Q, Q_n, TC);
`endif

endinterface

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop, rising edge, synchronous active-high clear.
module jk_ff_sync
    import jk_mod_counter_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_n
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        case (jk_op_e'({J, K}))
            HOLD:    q_d = q_q;
            RESET:   q_d = 1'b0;
            SET:     q_d = 1'b1;
            TOGGLE:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign Q_n = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from jk_ff_sync bits with parallel load.
// Define JK_CNT_GRAY_OUT_EN to add the registered Gray-code output G.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic              CLK,
    input  logic              CLR,
    jk_mod_counter_if.slave   bus
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    jk_op_e           op;

    // Target value first, then each bit only gets SET/RESET where it must change.
    always_comb begin
        q_next = q;
        if (bus.LOAD) begin
            q_next = ({1'b0, bus.D} < MOD_W) ? bus.D : '0;
        end else if (bus.EN) begin
            if ({1'b0, q} >= MOD_W) begin
                q_next = '0;
            end else if (bus.UP) begin
                q_next = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            end else begin
                q_next = (q == '0) ? MAX_Q : q - WIDTH'(1);
            end
        end

        j  = '0;
        k  = '0;
        op = HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_next[i] == q[i]) begin
                op = HOLD;
            end else if (q_next[i]) begin
                op = SET;
            end else begin
                op = RESET;
            end
            {j[i], k[i]} = op;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_sync u_ff (
            .CLK (CLK),
            .CLR (CLR),
            .J   (j[i]),
            .K   (k[i]),
            .Q   (q[i]),
            .Q_n (q_n[i])
        );
    end

    assign bus.Q   = q;
    assign bus.Q_n = q_n;
    assign bus.TC  = bus.EN & ~bus.LOAD & ~CLR &
                     ((bus.UP & (q == MAX_Q)) | (~bus.UP & (q == '0)));

`ifdef JK_CNT_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] gray_q;

    always_comb begin
        gray_d = q_next ^ (q_next >> 1);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign bus.G = gray_q;
`endif

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter state width in bits.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port CLR  input  1  reset: synchronous, active-high.
REQ-005 Port EN  input  1  count enable.
REQ-006 Port UP  input  1  direction: 1 = up, 0 = down.
REQ-007 Port LOAD  input  1  parallel load strobe.
REQ-008 Port D  input  WIDTH  parallel load value.
REQ-009 Port Q  output  WIDTH  current count, registered.
REQ-010 Port Q_n  output  WIDTH  bitwise complement of Q.
REQ-011 Port TC  output  1  terminal-count flag, combinational.

Function
REQ-012 The block SHALL hold each state bit in one jk_ff_sync instance; next-state logic SHALL drive only J/K, never Q directly.
REQ-013 The block SHALL apply this per-edge priority: CLR, then LOAD, then EN count, then hold.
REQ-014 With LOAD=1, the block SHALL set Q=D on the next edge if D<MODULUS, else Q=0; EN and UP are ignored.
REQ-015 With EN=1, LOAD=0 and UP=1, the block SHALL step Q by +1, wrapping MODULUS-1 to 0.
REQ-016 With EN=1, LOAD=0 and UP=0, the block SHALL step Q by -1, wrapping 0 to MODULUS-1.
REQ-017 With EN=0 and LOAD=0, the block SHALL hold Q (J=K=0 on all bits).
REQ-018 The block SHALL assert TC = EN & ~LOAD & ~CLR & ((UP & Q==MODULUS-1) | (~UP & Q==0)), marking the cycle whose edge wraps.
REQ-019 The block SHALL update Q one edge after the qualifying inputs, with no additional latency.
REQ-020 If Q holds an out-of-range value (MODULUS<2^WIDTH only), the block SHALL advance it to 0 on the next count edge in either direction.
REQ-021 A UP change mid-sequence SHALL take effect on the same edge, with no dead cycle.

Reset
REQ-022 The block SHALL force Q=0, Q_n=all-ones and TC=0 on any edge with CLR=1, regardless of EN/LOAD.
REQ-023 The block SHALL resume counting from 0 on the first edge after CLR deasserts.
REQ-024 Q after power-up without CLR is undefined; the bench SHALL apply CLR for ≥1 edge before checking.

Configuration
REQ-025 With JK_CNT_GRAY_OUT_EN defined, the block SHALL add output G (WIDTH), a registered Gray code of the next Q updated on the same edge as Q (G = Q ^ (Q>>1)), reset to 0 by CLR.
REQ-026 Without JK_CNT_GRAY_OUT_EN defined, port G and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 The shared package SHALL hold the default WIDTH/MODULUS constants and the J/K encoding constants HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11.
REQ-028 One sub-module, jk_ff_sync, SHALL be used: posedge JK flip-flop with synchronous active-high CLR, outputs Q and Q_n, truth table per the package encoding.
REQ-029 The top level SHALL contain only J/K decode, TC decode, the jk_ff_sync instances and, under the macro, the Gray register.

Verification
REQ-030 CLR=1 for 2 edges, then EN=1, UP=1 for 12 edges -> Q = 0,1,..,9,0,1; TC=1 only while Q=9.
REQ-031 Q=0, EN=1, UP=0 for 3 edges -> Q = 9,8,7; TC=1 on the cycle with Q=0.
REQ-032 LOAD=1, D=7, EN=1 for 1 edge -> Q=7; then LOAD=1, D=12 -> Q=0; TC=0 while LOAD=1.
REQ-033 Q=5, CLR=1 and LOAD=1 with D=3 on the same edge -> Q=0, Q_n=4'b1111.
REQ-034 EN=0 for 5 edges at Q=4 -> Q stays 4, TC=0; with UP toggled each edge while EN=1 from Q=4 -> Q = 5,4,5,4.
REQ-035 With JK_CNT_GRAY_OUT_EN defined, counting up 0..9 -> G = 0,1,3,2,6,7,5,4,12,13, always equal to Q^(Q>>1).
